// File: rtl/t13_priority_encoder_seq.sv
// Sequential priority encoder: captures a request vector, then emits the set-bit indices MSB first, one per accepted cycle.
// Optional zero-capture pulse output `nol` is enabled by defining T13_ZERO_FLAG_EN.
module t13_priority_encoder_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] masukan,
  input  logic        masukan_valid,
  output logic        masukan_ready,
  output logic [3:0]  keluaran,
  output logic        keluaran_valid,
  input  logic        keluaran_ready,
  output logic [4:0]  sisa
`ifdef T13_ZERO_FLAG_EN
  ,
  output logic        nol
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [15:0] pending, pending_next;
  logic [3:0]  top_idx;
  logic [4:0]  pop_cnt;

  // Ascending scan so the last hit, the most-significant set bit, wins.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pending[i]) top_idx = 4'(i);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + 5'(pending[i]);
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    unique case (state)
      IDLE: begin
        if (masukan_valid && (masukan != '0)) begin
          pending_next = masukan;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (keluaran_ready) begin
          pending_next          = pending;
          pending_next[top_idx] = 1'b0;
          if (pending_next == '0) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  assign masukan_ready  = (state == IDLE);
  assign keluaran_valid = (state == SEND);
  assign keluaran       = (state == SEND) ? top_idx : '0;
  assign sisa           = pop_cnt;

`ifdef T13_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) nol <= 1'b0;
    else     nol <= (state == IDLE) && masukan_valid && (masukan == '0);
  end
`endif

endmodule

// File: doc/t13_priority_encoder_seq.md
T13_PRIORITY_ENCODER_SEQ -- requirements
Module: t13_priority_encoder_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port masukan, input, 16 bits: one-hot or multi-hot request vector to encode.
REQ-004 SHALL have port masukan_valid, input, 1 bit: masukan is valid this cycle.
REQ-005 SHALL have port masukan_ready, output, 1 bit: block can accept a vector this cycle.
REQ-006 SHALL have port keluaran, output, 4 bits: index of the highest set bit still pending.
REQ-007 SHALL have port keluaran_valid, output, 1 bit: keluaran is valid this cycle.
REQ-008 SHALL have port keluaran_ready, input, 1 bit: downstream consumes keluaran this cycle.
REQ-009 SHALL have port sisa, output, 5 bits: number of set bits in the pending register, 0..16.
REQ-010 SHALL have port nol, output, 1 bit, only when T13_ZERO_FLAG_EN is defined (see REQ-027).

Function
REQ-011 SHALL implement two states: IDLE and SEND.
REQ-012 SHALL assert masukan_ready only in IDLE, and SHALL assert keluaran_valid only in SEND.
REQ-013 SHALL, in IDLE on masukan_valid=1, capture masukan into a 16-bit pending register at that clock edge.
REQ-014 SHALL move from IDLE to SEND on capture of a nonzero vector, and SHALL stay in IDLE on capture of a zero vector, with the vector dropped.
REQ-015 SHALL drive keluaran in SEND as the index of the most-significant set pending bit (bit 15 highest priority), decoded combinationally from the pending register.
REQ-016 SHALL hold keluaran and keluaran_valid stable while keluaran_valid=1 and keluaran_ready=0.
REQ-017 SHALL, on a SEND cycle with keluaran_ready=1, clear the pending bit at index keluaran at that edge.
REQ-018 SHALL stay in SEND after a clear that leaves bits pending, presenting the next index in the following cycle (throughput one index per cycle).
REQ-019 SHALL return to IDLE after a clear that leaves zero bits pending; masukan_ready SHALL be 1 in the next cycle.
REQ-020 SHALL have a latency of one cycle: keluaran_valid=1 in the cycle after the capture edge.
REQ-021 SHALL ignore masukan and masukan_valid while in SEND; no new capture occurs in the cycle of the final clear.
REQ-022 SHALL drive sisa as the popcount of the pending register every cycle; it SHALL be 0 in IDLE.
REQ-023 SHALL have keluaran=0 whenever keluaran_valid=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear the pending register and enter IDLE; rst overrides any simultaneous capture or clear.
REQ-025 SHALL drive the following output values after reset: masukan_ready=1, keluaran_valid=0, keluaran=0, sisa=0, nol=0.
REQ-026 SHALL, on reset asserted mid-SEND, discard all pending bits; keluaran_valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-027 SHALL, with T13_ZERO_FLAG_EN defined, provide output nol: a registered one-cycle pulse (cycle after the edge) when a zero vector is captured in IDLE.
REQ-028 SHALL, without T13_ZERO_FLAG_EN, have no nol port, and zero vectors SHALL be dropped silently with otherwise identical behaviour.

Verification
REQ-029 SHALL cover: reset, then masukan=16'h0001 with valid for 1 cycle and keluaran_ready=1 -> next cycle keluaran=0, keluaran_valid=1, sisa=1; one cycle later IDLE with masukan_ready=1.
REQ-030 SHALL cover: masukan=16'h8421 captured with keluaran_ready=1 held -> keluaran 15,10,5,0 on four consecutive cycles, sisa 4,3,2,1, then IDLE.
REQ-031 SHALL cover: masukan=16'h0300 captured, keluaran_ready=0 for 3 cycles -> keluaran=9 held stable with valid=1 and sisa=2; after ready=1, keluaran=8.
REQ-032 SHALL cover: masukan=16'hFFFF captured, rst=1 after 2 consumed indices -> next cycle keluaran_valid=0, sisa=0, masukan_ready=1.
REQ-033 SHALL cover: masukan=16'h0000 with valid in IDLE -> state stays IDLE, keluaran_valid stays 0; with T13_ZERO_FLAG_EN, nol=1 for exactly one cycle.
REQ-034 SHALL cover: masukan_valid=1 with masukan=16'h0004 while in SEND on vector 16'h0002 -> only index 1 is emitted, and the 16'h0004 vector is not captured.
